// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative floating-point multiplier.
package fp_pkg;

  localparam int E_WIDTH_DEF = 8;
  localparam int F_WIDTH_DEF = 23;

  // Canonical encodings at the default single-precision widths
  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;
  localparam logic [31:0] INF_32  = 32'h7F80_0000;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ROUND, ST_DONE} state_e;

  function automatic int fp_bias(input int e_width);
    return (1 << (e_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_iter_if.sv
// Operand/result valid-ready handshake bundle for fp_mul_iter.
interface fp_mul_iter_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] para1;
  logic [W-1:0] para2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output in_valid, para1, para2, out_ready,
    input  in_ready, out_valid, out, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, para1, para2, out_ready,
    output in_ready, out_valid, out, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_round_norm.sv
// Normalises the raw significand product, rounds to nearest-even and packs the
// result, saturating to signed inf / signed zero outside the normal range.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter  int E_WIDTH = E_WIDTH_DEF,
  parameter  int F_WIDTH = F_WIDTH_DEF,
  localparam int N       = F_WIDTH + 1,
  localparam int W       = 1 + E_WIDTH + F_WIDTH,
  localparam int EXW     = E_WIDTH + 2
) (
  input  logic [2*N-1:0]        prod,
  input  logic signed [EXW-1:0] exp_sum,
  input  logic                  sign,
  output logic [W-1:0]          result,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic signed [EXW-1:0] E_ONE  = EXW'(1);
  localparam logic signed [EXW-1:0] E_ZERO = '0;
  localparam logic signed [EXW-1:0] E_MAX  = EXW'((1 << E_WIDTH) - 1);

  logic [N-1:0]          sig;
  logic                  guard;
  logic                  sticky;
  logic signed [EXW-1:0] e;
  logic [N:0]            rounded;
  logic [F_WIDTH-1:0]    frac;

  always_comb begin
    sig       = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    e         = exp_sum;
    rounded   = '0;
    frac      = '0;
    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;

    // Product of two [1,2) significands lies in [1,4)
    if (prod[2*N-1]) begin
      sig    = prod[2*N-1 -: N];
      guard  = prod[N-1];
      sticky = |prod[N-2:0];
      e      = e + E_ONE;
    end else begin
      sig    = prod[2*N-2 -: N];
      guard  = prod[N-2];
      sticky = |prod[N-3:0];
    end

    rounded = {1'b0, sig} + {{N{1'b0}}, guard & (sticky | sig[0])};
    if (rounded[N]) begin
      frac = rounded[N-1:1];
      e    = e + E_ONE;
    end else begin
      frac = rounded[F_WIDTH-1:0];
    end

    overflow  = (e >= E_MAX);
    underflow = (e <= E_ZERO);

    if (overflow)
      result = {sign, {E_WIDTH{1'b1}}, {F_WIDTH{1'b0}}};
    else if (underflow)
      result = {sign, {(W-1){1'b0}}};
    else
      result = {sign, e[E_WIDTH-1:0], frac};
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Sequential floating-point multiplier: radix-2 shift-add significand product,
// round-to-nearest-even, zero/inf/NaN bypass, valid/ready on both sides.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand pair, in_ready high
// ST_MUL   | one multiplier bit per cycle, LSB first, cnt counts down
// ST_ROUND | normalise/round the product, register result and flags
// ST_DONE  | out_valid held until out_ready
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int E_WIDTH = E_WIDTH_DEF,
  parameter int F_WIDTH = F_WIDTH_DEF
) (
  input logic          clk,
  input logic          rst,
  fp_mul_iter_if.slave bus
);

  localparam int E_BIAS = fp_bias(E_WIDTH);
  localparam int W      = 1 + E_WIDTH + F_WIDTH;
  localparam int N      = F_WIDTH + 1;
  localparam int EXW    = E_WIDTH + 2;
  localparam int CW     = $clog2(N);

  localparam logic [W-1:0] QNAN = {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(F_WIDTH-1){1'b0}}};

  state_e                state;
  logic [2*N-1:0]        mcand;
  logic [2*N-1:0]        prod;
  logic [N-1:0]          mplier;
  logic signed [EXW-1:0] exp_sum;
  logic                  sign_q;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          result_q;
  logic                  out_valid_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  inv_q;

  logic                  s1, s2, sign_nxt;
  logic [E_WIDTH-1:0]    e1, e2;
  logic [F_WIDTH-1:0]    f1, f2;
  fp_class_e             c1, c2;

  logic [W-1:0]          rn_result;
  logic                  rn_ovf;
  logic                  rn_unf;

  function automatic fp_class_e classify(input logic [E_WIDTH-1:0] e,
                                         input logic [F_WIDTH-1:0] f);
    if (e == '0)
      return CLS_ZERO;
    else if (e == '1)
      return (f == '0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

  assign s1       = bus.para1[W-1];
  assign e1       = bus.para1[W-2 -: E_WIDTH];
  assign f1       = bus.para1[F_WIDTH-1:0];
  assign s2       = bus.para2[W-1];
  assign e2       = bus.para2[W-2 -: E_WIDTH];
  assign f2       = bus.para2[F_WIDTH-1:0];
  assign sign_nxt = s1 ^ s2;
  assign c1       = classify(e1, f1);
  assign c2       = classify(e2, f2);

  fp_round_norm #(.E_WIDTH(E_WIDTH), .F_WIDTH(F_WIDTH)) u_round_norm (
    .prod      (prod),
    .exp_sum   (exp_sum),
    .sign      (sign_q),
    .result    (rn_result),
    .overflow  (rn_ovf),
    .underflow (rn_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mcand       <= '0;
      prod        <= '0;
      mplier      <= '0;
      exp_sum     <= '0;
      sign_q      <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_q <= sign_nxt;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inv_q  <= 1'b0;
            // Bypass priority: NaN, inf*0, inf, zero
            if (c1 == CLS_NAN || c2 == CLS_NAN) begin
              result_q    <= QNAN;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if ((c1 == CLS_INF && c2 == CLS_ZERO) ||
                         (c1 == CLS_ZERO && c2 == CLS_INF)) begin
              result_q    <= QNAN;
              inv_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if (c1 == CLS_INF || c2 == CLS_INF) begin
              result_q    <= {sign_nxt, {E_WIDTH{1'b1}}, {F_WIDTH{1'b0}}};
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else if (c1 == CLS_ZERO || c2 == CLS_ZERO) begin
              result_q    <= {sign_nxt, {(W-1){1'b0}}};
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              mcand   <= {{N{1'b0}}, 1'b1, f1};
              mplier  <= {1'b1, f2};
              prod    <= '0;
              exp_sum <= EXW'({2'b00, e1}) + EXW'({2'b00, e2}) - EXW'(E_BIAS);
              cnt     <= CW'(N - 1);
              state   <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (mplier[0])
            prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0)
            state <= ST_ROUND;
          else
            cnt <= cnt - 1'b1;
        end
        ST_ROUND: begin
          result_q    <= rn_result;
          ovf_q       <= rn_ovf;
          unf_q       <= rn_unf;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: directed vector table, backpressure and mid-operation
// reset sequences, and random operands against an integer-arithmetic model.
module tb_fp_mul_iter;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_iter_if #(.W(32)) bus ();

  fp_mul_iter #(.E_WIDTH(8), .F_WIDTH(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;   // {overflow, underflow, invalid}
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, then round-half-even by remainder compare.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] f,
                                  output int lat);
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    logic s;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned p, q, rem, half;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0];        fb = b[22:0];
    s  = a[31] ^ b[31];
    a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);               b_zero = (eb == 0);
    f = 3'b000;
    lat = 1;
    if (a_nan || b_nan) begin
      r = QNAN_32;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      r = QNAN_32; f = 3'b001;
    end else if (a_inf || b_inf) begin
      r = INF_32 | {s, 31'b0};
    end else if (a_zero || b_zero) begin
      r = {s, 31'b0};
    end else begin
      lat = 26;
      p = (64'h80_0000 + 64'(fa)) * (64'h80_0000 + 64'(fb));
      e = ea + eb - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r = INF_32 | {s, 31'b0}; f = 3'b100;
      end else if (e <= 0) begin
        r = {s, 31'b0}; f = 3'b010;
      end else begin
        r = {s, 8'(e), q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] gen_op();
    int k;
    logic [7:0]  e;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    f = 23'($urandom);
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'd255; f = '0; end
      2:       begin e = 8'd255; f = f | 23'd1; end
      3, 4:    e = 8'($urandom_range(1, 254));
      5:       begin e = 8'($urandom_range(100, 150)); f = f & 23'h7; end
      default: e = 8'($urandom_range(96, 158));
    endcase
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // Presents one operand pair; returns the result, flags and latency in cycles
  // (accept cycle T to first out_valid cycle). lat=-1 means the result never came.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [2:0] flg, output int lat);
    int k;
    bus.para1 = a;
    bus.para2 = b;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 100) begin @(posedge clk); #1; k++; end
    lat = bus.out_valid ? k + 1 : -1;
    res = bus.out;
    flg = {bus.overflow, bus.underflow, bus.invalid};
    if (bus.out_ready) begin @(posedge clk); #1; end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] res, held_res, a, b, er;
    logic [2:0]  flg, held_flg, ef;
    int lat, el;
    bit seen_valid;

    vecs.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26});
    vecs.push_back('{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 26});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 26});
    vecs.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 26});
    vecs.push_back('{32'h80800000, 32'h00800000, 32'h80000000, 3'b010, 26});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 26});
    vecs.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, 26});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 26});
    vecs.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 26});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 1});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1});
    vecs.push_back('{32'h80000000, 32'h40A00000, 32'h80000000, 3'b000, 1});
    vecs.push_back('{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 3'b000, 1});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 1});

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.para1 = '0;
    bus.para2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out", 64'(bus.out), 64'd0);
    check("reset_flags", 64'({bus.overflow, bus.underflow, bus.invalid}), 64'd0);
    check("reset_in_ready_low", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, res, flg, lat);
      check($sformatf("vec%0d_out", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'(flg), 64'(vecs[i].flg));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: result and flags held, no new accept while stalled
    bus.out_ready = 1'b0;
    do_op(32'h7F000000, 32'h7F000000, held_res, held_flg, lat);
    check("bp_out", 64'(held_res), 64'h7F800000);
    check("bp_flags", 64'(held_flg), 64'(3'b100));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", c),
            64'({bus.out_valid, bus.in_ready, bus.out, bus.overflow, bus.underflow, bus.invalid}),
            64'({1'b1, 1'b0, held_res, held_flg}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a multiply aborts it silently
    bus.para1 = 32'h3FC00000;
    bus.para2 = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      seen_valid |= bus.out_valid;
    end
    check("midrst_no_out_valid", 64'(seen_valid), 64'd0);
    do_op(32'h3FC00000, 32'h40000000, res, flg, lat);
    check("midrst_next_out", 64'(res), 64'h40400000);
    check("midrst_next_latency", 64'(lat), 64'd26);

    for (int i = 0; i < 60; i++) begin
      a = gen_op();
      b = gen_op();
      ref_mul(a, b, er, ef, el);
      do_op(a, b, res, flg, lat);
      check($sformatf("rand%0d_out(%h*%h)", i, a, b), 64'(res), 64'(er));
      check($sformatf("rand%0d_flags", i), 64'(flg), 64'(ef));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(el));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
